// File: rtl/alu_exec_pkg.sv
// ============================================================================
// Module  : alu_exec_pkg
// Purpose : Shared types and constants for the execute-stage sequencer and
//           its alu. Optional feature macro used by the slice: ALU_EXEC_IMM_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CONST_ALU_INOUT_WIDTH
`define CONST_ALU_INOUT_WIDTH 16
`endif
`ifndef CONST_PROC_FLAGS_MSB_POS
`define CONST_PROC_FLAGS_MSB_POS 3
`endif

package alu_exec_pkg;
    localparam int DATA_W  = `CONST_ALU_INOUT_WIDTH;
    localparam int FLAGS_W = `CONST_PROC_FLAGS_MSB_POS + 1;
    // Register index width carried inside a request record (sized for 16 regs)
    localparam int IDX_W   = 4;

    localparam int pf_slot_c = 0;
    localparam int pf_slot_z = 1;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_LSL = 4'h7;

    // Only the carry and zero bits are committed to the flags register
    localparam logic [FLAGS_W-1:0] CZ_MASK =
        FLAGS_W'((1 << pf_slot_c) | (1 << pf_slot_z));

    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

    typedef struct packed {
        logic [3:0]        oper;
        logic [IDX_W-1:0]  rd;
        logic [IDX_W-1:0]  ra;
        logic [IDX_W-1:0]  rb;
        logic              use_imm;
        logic [DATA_W-1:0] imm;
    } req_t;
endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module  : alu
// Purpose : Combinational ALU. Unknown opcodes pass a_in and leave flags as-is.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu
    import alu_exec_pkg::*;
(
    input  logic [3:0]         oper,
    input  logic [DATA_W-1:0]  a_in,
    input  logic [DATA_W-1:0]  b_in,
    input  logic [FLAGS_W-1:0] proc_flags_in,
    output logic [DATA_W-1:0]  out,
    output logic [FLAGS_W-1:0] proc_flags_out
);
    logic [DATA_W:0] wide;

    // Result and carry/zero computation per opcode
    always_comb begin
        out            = a_in;
        proc_flags_out = proc_flags_in;
        wide           = '0;
        case (oper)
            OP_ADD, OP_ADC: begin
                wide = {1'b0, a_in} + {1'b0, b_in}
                     + {{DATA_W{1'b0}}, (oper == OP_ADC) & proc_flags_in[pf_slot_c]};
                out  = wide[DATA_W-1:0];
                proc_flags_out[pf_slot_c] = wide[DATA_W];
                proc_flags_out[pf_slot_z] = (wide[DATA_W-1:0] == '0);
            end
            OP_SUB, OP_CMP: begin
                // Carry means "no borrow" (a >= b)
                wide = {1'b0, a_in} - {1'b0, b_in};
                out  = wide[DATA_W-1:0];
                proc_flags_out[pf_slot_c] = ~wide[DATA_W];
                proc_flags_out[pf_slot_z] = (wide[DATA_W-1:0] == '0);
            end
            OP_AND, OP_OR, OP_XOR: begin
                if (oper == OP_AND)     out = a_in & b_in;
                else if (oper == OP_OR) out = a_in | b_in;
                else                    out = a_in ^ b_in;
                proc_flags_out[pf_slot_z] = ((oper == OP_AND) ? ((a_in & b_in) == '0) :
                                             (oper == OP_OR)  ? ((a_in | b_in) == '0) :
                                                                ((a_in ^ b_in) == '0));
            end
            OP_LSL: begin
                // A zero shift is a pure move and leaves the flags untouched
                wide = {1'b0, a_in} << b_in;
                out  = wide[DATA_W-1:0];
                if (b_in != '0) begin
                    proc_flags_out[pf_slot_c] = wide[DATA_W];
                    proc_flags_out[pf_slot_z] = (wide[DATA_W-1:0] == '0);
                end
            end
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/alu_exec_regfile.sv
// ============================================================================
// Module  : alu_exec_regfile
// Purpose : NUM_REGS x DATA_W register file: one write port, two registered
//           operand read ports, one asynchronous debug read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_regfile
    import alu_exec_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 rd_en,
    input  logic [REG_IDX_W-1:0] ra,
    input  logic [REG_IDX_W-1:0] rb,
    output logic [DATA_W-1:0]    a_data,
    output logic [DATA_W-1:0]    b_data,
    input  logic [REG_IDX_W-1:0] dbg_idx,
    output logic [DATA_W-1:0]    dbg_data
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Single write port; callers guarantee load and writeback never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    // Operand snapshot, taken only when enabled so it holds through execute
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data <= '0;
            b_data <= '0;
        end else if (rd_en) begin
            a_data <= regs[ra];
            b_data <= regs[rb];
        end
    end

    assign dbg_data = regs[dbg_idx];
endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// ============================================================================
// Module  : alu_exec_ctrl
// Purpose : Execute-stage sequencer (IDLE->READ->EXEC->WB) driving an alu,
//           with register-file writeback and carry/zero flag commit.
//           Optional macro ALU_EXEC_IMM_EN adds an immediate B operand.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_oper,
    input  logic [REG_IDX_W-1:0] req_rd,
    input  logic [REG_IDX_W-1:0] req_ra,
    input  logic [REG_IDX_W-1:0] req_rb,
`ifdef ALU_EXEC_IMM_EN
    input  logic                 req_use_imm,
    input  logic [DATA_W-1:0]    req_imm,
`endif
    input  logic                 ld_en,
    input  logic [REG_IDX_W-1:0] ld_idx,
    input  logic [DATA_W-1:0]    ld_data,
    input  logic [REG_IDX_W-1:0] dbg_idx,
    output logic [DATA_W-1:0]    dbg_data,
    output logic                 done_valid,
    output logic [DATA_W-1:0]    done_result,
    output logic [FLAGS_W-1:0]   flags_out
);
    state_t             state;
    req_t               req_q;
    logic [DATA_W-1:0]  res_q;
    logic [FLAGS_W-1:0] fl_q;
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_reg;
    logic [DATA_W-1:0]  b_q;
    logic [DATA_W-1:0]  alu_out;
    logic [FLAGS_W-1:0] alu_flags;
    logic               wb_write;
    logic               rf_we;

    assign req_ready = (state == IDLE) && !ld_en;
    assign b_q       = req_q.use_imm ? req_q.imm : b_reg;

    // Compare only updates flags; everything else writes its destination
    assign wb_write  = (state == WB) && (req_q.oper != OP_CMP);
    assign rf_we     = ((state == IDLE) && ld_en) || wb_write;

    alu_exec_regfile #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (rf_we),
        .waddr    (wb_write ? REG_IDX_W'(req_q.rd) : ld_idx),
        .wdata    (wb_write ? res_q : ld_data),
        .rd_en    (state == READ),
        .ra       (REG_IDX_W'(req_q.ra)),
        .rb       (REG_IDX_W'(req_q.rb)),
        .a_data   (a_q),
        .b_data   (b_reg),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    alu u_alu (
        .oper           (req_q.oper),
        .a_in           (a_q),
        .b_in           (b_q),
        .proc_flags_in  (flags_out),
        .out            (alu_out),
        .proc_flags_out (alu_flags)
    );

    // Sequencer with registered completion outputs and flag commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            res_q       <= '0;
            fl_q        <= '0;
            done_valid  <= 1'b0;
            done_result <= '0;
            flags_out   <= '0;
        end else begin
            done_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_q.oper <= req_oper;
                        req_q.rd   <= IDX_W'(req_rd);
                        req_q.ra   <= IDX_W'(req_ra);
                        req_q.rb   <= IDX_W'(req_rb);
`ifdef ALU_EXEC_IMM_EN
                        req_q.use_imm <= req_use_imm;
                        req_q.imm     <= req_imm;
`else
                        req_q.use_imm <= 1'b0;
                        req_q.imm     <= '0;
`endif
                        state <= READ;
                    end
                end
                READ: state <= EXEC;
                EXEC: begin
                    res_q <= alu_out;
                    fl_q  <= alu_flags;
                    state <= WB;
                end
                WB: begin
                    done_result <= res_q;
                    done_valid  <= 1'b1;
                    flags_out   <= (flags_out & ~CZ_MASK) | (fl_q & CZ_MASK);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
// ============================================================================
// Module  : tb_alu_exec_ctrl
// Purpose : Table-driven self-checking bench for alu_exec_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_oper = '0;
    logic [3:0]  req_rd = '0, req_ra = '0, req_rb = '0;
    logic        req_use_imm = 1'b0;
    logic [15:0] req_imm = '0;
    logic        ld_en = 1'b0;
    logic [3:0]  ld_idx = '0;
    logic [15:0] ld_data = '0;
    logic [3:0]  dbg_idx = '0;
    logic [15:0] dbg_data;
    logic        done_valid;
    logic [15:0] done_result;
    logic [3:0]  flags_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_oper    (req_oper),
        .req_rd      (req_rd),
        .req_ra      (req_ra),
        .req_rb      (req_rb),
`ifdef ALU_EXEC_IMM_EN
        .req_use_imm (req_use_imm),
        .req_imm     (req_imm),
`endif
        .ld_en       (ld_en),
        .ld_idx      (ld_idx),
        .ld_data     (ld_data),
        .dbg_idx     (dbg_idx),
        .dbg_data    (dbg_data),
        .done_valid  (done_valid),
        .done_result (done_result),
        .flags_out   (flags_out)
    );

    typedef struct {
        bit          is_ld;
        logic [3:0]  oper;
        logic [3:0]  rd, ra, rb;
        bit          use_imm;
        logic [15:0] data;      // load data, or immediate
        logic [15:0] exp_res;
        logic        exp_c, exp_z;
        logic [15:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_ld(input logic [3:0] idx, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_idx = idx; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        dbg_idx = idx; #1;
        chk("ld_readback", dbg_data, d);
    endtask

    // Issue one op and check done timing, result, C/Z and destination register
    task automatic run_op(input vec_t v);
        @(negedge clk);
        req_oper = v.oper; req_rd = v.rd; req_ra = v.ra; req_rb = v.rb;
        req_use_imm = v.use_imm; req_imm = v.data;
        req_valid = 1'b1;
        chk("ready_before", req_ready, 1);
        @(posedge clk); #1;                  // accept edge N
        req_valid = 1'b0;
        req_oper = 4'hE; req_rd = 4'hF; req_ra = 4'hF; req_rb = 4'hF;
        chk("ready_busy", req_ready, 0);
        @(posedge clk); #1;                  // N+1
        @(posedge clk); #1;                  // N+2
        chk("done_early", done_valid, 0);
        @(posedge clk); #1;                  // N+3
        chk("done_at_n3", done_valid, 1);
        chk("done_result", done_result, v.exp_res);
        chk("flag_c", flags_out[0], v.exp_c);
        chk("flag_z", flags_out[1], v.exp_z);
        dbg_idx = v.rd; #1;
        chk("rd_value", dbg_data, v.exp_rd);
        @(posedge clk); #1;
        chk("done_pulse", done_valid, 0);
    endtask

    vec_t vecs [14];
    vec_t v;

    initial begin
        //            ld  oper  rd    ra    rb    imm data     res      c     z     rd value
        vecs[0]  = '{1, 4'h0, 4'd1, 4'd0, 4'd0, 0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[1]  = '{1, 4'h0, 4'd2, 4'd0, 4'd0, 0, 16'h0003, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[2]  = '{0, 4'h0, 4'd3, 4'd1, 4'd2, 0, 16'h0,    16'h0008, 1'b0, 1'b0, 16'h0008};
        vecs[3]  = '{1, 4'h0, 4'd1, 4'd0, 4'd0, 0, 16'hFFFF, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[4]  = '{1, 4'h0, 4'd2, 4'd0, 4'd0, 0, 16'h0001, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[5]  = '{0, 4'h0, 4'd4, 4'd1, 4'd2, 0, 16'h0,    16'h0000, 1'b1, 1'b1, 16'h0000};
        vecs[6]  = '{0, 4'h1, 4'd5, 4'd0, 4'd0, 0, 16'h0,    16'h0001, 1'b0, 1'b0, 16'h0001};
        vecs[7]  = '{1, 4'h0, 4'd6, 4'd0, 4'd0, 0, 16'h1234, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[8]  = '{1, 4'h0, 4'd1, 4'd0, 4'd0, 0, 16'h0005, 16'h0, 1'b0, 1'b0, 16'h0};
        vecs[9]  = '{0, 4'h4, 4'd6, 4'd1, 4'd1, 0, 16'h0,    16'h0000, 1'b1, 1'b1, 16'h1234};
        vecs[10] = '{0, 4'h7, 4'd7, 4'd1, 4'd0, 0, 16'h0,    16'h0005, 1'b1, 1'b1, 16'h0005};
        vecs[11] = '{0, 4'h2, 4'd8, 4'd2, 4'd1, 0, 16'h0,    16'hFFFC, 1'b0, 1'b0, 16'hFFFC};
        vecs[12] = '{0, 4'h6, 4'd9, 4'd1, 4'd1, 0, 16'h0,    16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[13] = '{0, 4'hF, 4'd10, 4'd1, 4'd1, 0, 16'h0,   16'h0005, 1'b0, 1'b1, 16'h0005};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_result", done_result, 0);
        chk("rst_flags", flags_out, 0);
        dbg_idx = 4'd3; #1;
        chk("rst_reg", dbg_data, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_ld) do_ld(vecs[i].rd, vecs[i].data);
            else               run_op(vecs[i]);
        end

        // ld_en during an op is ignored: add r11 = r1(5) + r2(1) while loading r12
        @(negedge clk);
        req_oper = 4'h0; req_rd = 4'd11; req_ra = 4'd1; req_rb = 4'd2; req_use_imm = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;                  // accept
        req_valid = 1'b0;
        @(posedge clk); #1;                  // now EXEC
        ld_en = 1'b1; ld_idx = 4'd12; ld_data = 16'hBEEF;
        chk("ready_ld_busy", req_ready, 0);
        @(posedge clk); #1;                  // WB
        @(posedge clk); #1;                  // done
        ld_en = 1'b0;
        chk("ld_busy_done", done_valid, 1);
        chk("ld_busy_result", done_result, 16'h0006);
        dbg_idx = 4'd12; #1;
        chk("ld_busy_ignored", dbg_data, 16'h0000);
        dbg_idx = 4'd11; #1;
        chk("ld_busy_rd", dbg_data, 16'h0006);

        // Reset during EXEC aborts the op: add r3 = r1 + r2 (r3 currently 8)
        do_ld(4'd2, 16'h0003);
        @(negedge clk);
        req_oper = 4'h0; req_rd = 4'd3; req_ra = 4'd1; req_rb = 4'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;                  // accept
        req_valid = 1'b0;
        @(posedge clk); #2;                  // in EXEC
        rst = 1'b1;
        #1;
        chk("abort_done_valid", done_valid, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", req_ready, 1);
        dbg_idx = 4'd3; #1;
        chk("abort_r3", dbg_data, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done_valid, 0);
        end
        chk("abort_flags", flags_out, 0);

`ifdef ALU_EXEC_IMM_EN
        // Immediate operand: r8 = r1(0x0FF0) & 0x00F0
        do_ld(4'd1, 16'h0FF0);
        v = '{0, 4'h3, 4'd8, 4'd1, 4'd0, 1, 16'h00F0, 16'h00F0, 1'b0, 1'b0, 16'h00F0};
        run_op(v);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
